// File: rtl/cvxif_copro_responder.sv
// CV-X-IF coprocessor responder: decodes custom-3 ops, holds issued instructions in an
// in-order queue until commit/kill, then executes the head and returns one result per commit.
module cvxif_copro_responder #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned IdWidth = 3,
    parameter int unsigned Depth   = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               x_issue_valid_i,
    output logic               x_issue_ready_o,
    input  logic [31:0]        x_issue_instr_i,
    input  logic [IdWidth-1:0] x_issue_id_i,
    input  logic [XLEN-1:0]    x_issue_rs1_i,
    input  logic [XLEN-1:0]    x_issue_rs2_i,
    input  logic [1:0]         x_issue_rs_valid_i,
    output logic               x_issue_accept_o,
    output logic               x_issue_writeback_o,
    input  logic               x_commit_valid_i,
    input  logic [IdWidth-1:0] x_commit_id_i,
    input  logic               x_commit_kill_i,
    output logic               x_result_valid_o,
    input  logic               x_result_ready_i,
    output logic [IdWidth-1:0] x_result_id_o,
    output logic [XLEN-1:0]    x_result_data_o,
    output logic [4:0]         x_result_rd_o,
    output logic               x_result_we_o,
    output logic               x_result_exc_o,
    output logic [5:0]         x_result_exccode_o
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned ShW  = $clog2(XLEN);
    localparam logic [6:0] OpcCustom3 = 7'b1111011;
    localparam logic [1:0] OpAdd = 2'b00;
    localparam logic [1:0] OpShl = 2'b01;
    localparam logic [1:0] OpExc = 2'b11;

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;

    function automatic logic [XLEN-1:0] calc_result(input logic [1:0] op,
                                                    input logic [XLEN-1:0] a,
                                                    input logic [XLEN-1:0] b);
        case (op)
            OpAdd:   calc_result = a + b;
            OpShl:   calc_result = a << b[ShW-1:0];
            default: calc_result = '0;
        endcase
    endfunction

    state_e             state_q, state_d;
    logic [1:0]         lat_q, lat_d;
    logic [Depth-1:0]   vld_q, vld_d, cmt_q, cmt_d, kill_q, kill_d;
    logic [IdWidth-1:0] id_q [Depth];
    logic [IdWidth-1:0] id_d [Depth];
    logic [4:0]         rd_q [Depth];
    logic [1:0]         op_q [Depth];
    logic [XLEN-1:0]    rs1_q [Depth];
    logic [XLEN-1:0]    rs2_q [Depth];
    logic [PtrW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [PtrW:0]      cnt_q, cnt_d;
    logic               full_q;
    logic               dec_ok_s, enq_s, pop_s, load_res_s, unused_s;

    // Funct3 values 000..011 are exactly those with instr[14] clear.
    assign dec_ok_s            = (x_issue_instr_i[6:0] == OpcCustom3) && (x_issue_instr_i[14] == 1'b0);
    assign x_issue_accept_o    = dec_ok_s;
    assign x_issue_writeback_o = dec_ok_s && (x_issue_instr_i[13] == 1'b0);
    assign x_issue_ready_o     = rst_ni && !full_q && (x_issue_rs_valid_i == 2'b11);
    assign enq_s               = x_issue_valid_i && x_issue_ready_o && dec_ok_s;
    assign unused_s            = ^x_issue_instr_i[31:15];

    // Execution FSM: wait for a committed head, count its latency, present the result.
    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        pop_s      = 1'b0;
        load_res_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (vld_q[head_q] && cmt_q[head_q]) begin
                    if (kill_q[head_q]) begin
                        pop_s = 1'b1;
                    end else begin
                        state_d = EXEC;
                        lat_d   = (op_q[head_q] == OpShl) ? 2'd3 : 2'd0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                if (lat_q == 2'd0) begin
                    state_d    = RESP;
                    load_res_s = 1'b1;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            RESP: begin
                if (x_result_ready_i) begin
                    pop_s   = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Queue bookkeeping; commit matching runs after enqueue so a same-cycle commit hits the new entry.
    always_comb begin
        vld_d  = vld_q;
        cmt_d  = cmt_q;
        kill_d = kill_q;
        id_d   = id_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (pop_s) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + PtrW'(1);
            cnt_d         = cnt_d - (PtrW+1)'(1);
        end else begin
            head_d = head_q;
        end
        if (enq_s) begin
            vld_d[tail_q]  = 1'b1;
            cmt_d[tail_q]  = 1'b0;
            kill_d[tail_q] = 1'b0;
            id_d[tail_q]   = x_issue_id_i;
            tail_d         = tail_q + PtrW'(1);
            cnt_d          = cnt_d + (PtrW+1)'(1);
        end else begin
            tail_d = tail_q;
        end
        if (x_commit_valid_i) begin
            for (int i = 0; i < Depth; i++) begin
                if (vld_d[i] && !cmt_d[i] && (id_d[i] == x_commit_id_i)) begin
                    cmt_d[i]  = 1'b1;
                    kill_d[i] = x_commit_kill_i;
                end else begin
                    cmt_d[i] = cmt_d[i];
                end
            end
        end else begin
            cmt_d = cmt_d;
        end
    end

    // State, queue and result registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q            <= IDLE;
            lat_q              <= 2'd0;
            vld_q              <= '0;
            cmt_q              <= '0;
            kill_q             <= '0;
            head_q             <= '0;
            tail_q             <= '0;
            cnt_q              <= '0;
            full_q             <= 1'b0;
            x_result_valid_o   <= 1'b0;
            x_result_id_o      <= '0;
            x_result_data_o    <= '0;
            x_result_rd_o      <= 5'd0;
            x_result_we_o      <= 1'b0;
            x_result_exc_o     <= 1'b0;
            x_result_exccode_o <= 6'd0;
            for (int i = 0; i < Depth; i++) begin
                id_q[i]  <= '0;
                rd_q[i]  <= 5'd0;
                op_q[i]  <= 2'd0;
                rs1_q[i] <= '0;
                rs2_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            vld_q   <= vld_d;
            cmt_q   <= cmt_d;
            kill_q  <= kill_d;
            id_q    <= id_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == (PtrW+1)'(Depth));
            if (enq_s) begin
                rd_q[tail_q]  <= x_issue_instr_i[11:7];
                op_q[tail_q]  <= x_issue_instr_i[13:12];
                rs1_q[tail_q] <= x_issue_rs1_i;
                rs2_q[tail_q] <= x_issue_rs2_i;
            end
            if (load_res_s) begin
                x_result_valid_o   <= 1'b1;
                x_result_id_o      <= id_q[head_q];
                x_result_data_o    <= calc_result(op_q[head_q], rs1_q[head_q], rs2_q[head_q]);
                x_result_rd_o      <= rd_q[head_q];
                x_result_we_o      <= (op_q[head_q] == OpAdd) || (op_q[head_q] == OpShl);
                x_result_exc_o     <= (op_q[head_q] == OpExc);
                x_result_exccode_o <= (op_q[head_q] == OpExc) ? 6'd2 : 6'd0;
            end else if (x_result_valid_o && x_result_ready_i) begin
                x_result_valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cvxif_copro_responder.sv
// Scoreboard bench: stimulus pushes expected results, a negedge monitor pops and compares them.
module tb_cvxif_copro_responder;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        x_issue_valid_i = 1'b0;
    logic        x_issue_ready_o;
    logic [31:0] x_issue_instr_i = 32'd0;
    logic [2:0]  x_issue_id_i = 3'd0;
    logic [63:0] x_issue_rs1_i = 64'd0;
    logic [63:0] x_issue_rs2_i = 64'd0;
    logic [1:0]  x_issue_rs_valid_i = 2'b11;
    logic        x_issue_accept_o;
    logic        x_issue_writeback_o;
    logic        x_commit_valid_i = 1'b0;
    logic [2:0]  x_commit_id_i = 3'd0;
    logic        x_commit_kill_i = 1'b0;
    logic        x_result_valid_o;
    logic        x_result_ready_i = 1'b1;
    logic [2:0]  x_result_id_o;
    logic [63:0] x_result_data_o;
    logic [4:0]  x_result_rd_o;
    logic        x_result_we_o;
    logic        x_result_exc_o;
    logic [5:0]  x_result_exccode_o;

    cvxif_copro_responder dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .x_issue_valid_i(x_issue_valid_i), .x_issue_ready_o(x_issue_ready_o),
        .x_issue_instr_i(x_issue_instr_i), .x_issue_id_i(x_issue_id_i),
        .x_issue_rs1_i(x_issue_rs1_i), .x_issue_rs2_i(x_issue_rs2_i),
        .x_issue_rs_valid_i(x_issue_rs_valid_i), .x_issue_accept_o(x_issue_accept_o),
        .x_issue_writeback_o(x_issue_writeback_o),
        .x_commit_valid_i(x_commit_valid_i), .x_commit_id_i(x_commit_id_i),
        .x_commit_kill_i(x_commit_kill_i),
        .x_result_valid_o(x_result_valid_o), .x_result_ready_i(x_result_ready_i),
        .x_result_id_o(x_result_id_o), .x_result_data_o(x_result_data_o),
        .x_result_rd_o(x_result_rd_o), .x_result_we_o(x_result_we_o),
        .x_result_exc_o(x_result_exc_o), .x_result_exccode_o(x_result_exccode_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0]  id;
        logic [63:0] data;
        logic [4:0]  rd;
        logic        we;
        logic        exc;
        logic [5:0]  code;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd);
        mk = {17'd0, f3, rd, 7'b1111011};
    endfunction

    task automatic push_exp(input logic [2:0] id, input logic [63:0] data, input logic [4:0] rd,
                            input logic we, input logic exc, input logic [5:0] code);
        exp_t e;
        e.id = id; e.data = data; e.rd = rd; e.we = we; e.exc = exc; e.code = code;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [2:0] id, input logic [63:0] a,
                         input logic [63:0] b, input logic exp_acc, input logic exp_wb,
                         input logic cmt);
        x_issue_valid_i = 1'b1; x_issue_instr_i = instr; x_issue_id_i = id;
        x_issue_rs1_i = a; x_issue_rs2_i = b; x_issue_rs_valid_i = 2'b11;
        x_commit_valid_i = cmt; x_commit_id_i = id; x_commit_kill_i = 1'b0;
        #1;
        chk("issue_ready", {63'd0, x_issue_ready_o}, 64'd1);
        chk("issue_accept", {63'd0, x_issue_accept_o}, {63'd0, exp_acc});
        chk("issue_writeback", {63'd0, x_issue_writeback_o}, {63'd0, exp_wb});
        step();
        x_issue_valid_i = 1'b0; x_commit_valid_i = 1'b0;
    endtask

    task automatic commit(input logic [2:0] id, input logic kill);
        x_commit_valid_i = 1'b1; x_commit_id_i = id; x_commit_kill_i = kill;
        step();
        x_commit_valid_i = 1'b0; x_commit_kill_i = 1'b0;
    endtask

    // Called right after issue() returns; lat is the number of cycles from issue to result_valid.
    task automatic expect_latency(input int lat);
        for (int j = 1; j < lat; j++) begin
            chk("latency_early", {63'd0, x_result_valid_o}, 64'd0);
            step();
        end
        chk("latency_valid", {63'd0, x_result_valid_o}, 64'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && (sb.size() != 0 || x_result_valid_o); k++) step();
        chk("drain_done", {63'd0, (sb.size() == 0 && !x_result_valid_o)}, 64'd1);
    endtask

    logic        held = 1'b0;
    logic [63:0] held_data;
    logic [2:0]  held_id;

    // Monitor: compare each result at its handshake and check stability while stalled.
    always @(negedge clk_i) begin
        if (rst_ni && x_result_valid_o) begin
            if (x_result_ready_i) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", {61'd0, x_result_id_o}, 64'h1ff);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("res_id", {61'd0, x_result_id_o}, {61'd0, e.id});
                    chk("res_data", x_result_data_o, e.data);
                    chk("res_rd", {59'd0, x_result_rd_o}, {59'd0, e.rd});
                    chk("res_we", {63'd0, x_result_we_o}, {63'd0, e.we});
                    chk("res_exc", {63'd0, x_result_exc_o}, {63'd0, e.exc});
                    chk("res_exccode", {58'd0, x_result_exccode_o}, {58'd0, e.code});
                end
                held = 1'b0;
            end else begin
                if (held) begin
                    chk("stall_data_stable", x_result_data_o, held_data);
                    chk("stall_id_stable", {61'd0, x_result_id_o}, {61'd0, held_id});
                end
                held_data = x_result_data_o;
                held_id   = x_result_id_o;
                held      = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic got_hs;
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_issue_ready", {63'd0, x_issue_ready_o}, 64'd0);
        chk("reset_result_valid", {63'd0, x_result_valid_o}, 64'd0);
        chk("reset_result_data", x_result_data_o, 64'd0);
        chk("reset_result_id", {61'd0, x_result_id_o}, 64'd0);
        rst_ni = 1'b1;
        step();

        // ADD 3+4, same-cycle commit, result three cycles after issue.
        push_exp(3'd1, 64'd7, 5'd5, 1'b1, 1'b0, 6'd0);
        issue(mk(3'b000, 5'd5), 3'd1, 64'd3, 64'd4, 1'b1, 1'b1, 1'b1);
        expect_latency(3);
        drain();

        // SHL 1<<8 with result backpressure for three cycles.
        x_result_ready_i = 1'b0;
        push_exp(3'd2, 64'd256, 5'd6, 1'b1, 1'b0, 6'd0);
        issue(mk(3'b001, 5'd6), 3'd2, 64'd1, 64'd8, 1'b1, 1'b1, 1'b1);
        expect_latency(6);
        repeat (3) step();
        chk("stall_valid_held", {63'd0, x_result_valid_o}, 64'd1);
        x_result_ready_i = 1'b1;
        drain();

        // Kill in the middle of three pending ADDs; last one wraps mod 2^64.
        push_exp(3'd0, 64'd30, 5'd1, 1'b1, 1'b0, 6'd0);
        push_exp(3'd2, 64'd1, 5'd3, 1'b1, 1'b0, 6'd0);
        issue(mk(3'b000, 5'd1), 3'd0, 64'd10, 64'd20, 1'b1, 1'b1, 1'b0);
        issue(mk(3'b000, 5'd2), 3'd1, 64'd1, 64'd1, 1'b1, 1'b1, 1'b0);
        issue(mk(3'b000, 5'd3), 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, 1'b1, 1'b0);
        commit(3'd0, 1'b0);
        commit(3'd1, 1'b1);
        commit(3'd2, 1'b0);
        drain();

        // Non-custom opcode completes the handshake but is not queued.
        issue(32'h0000_0033, 3'd5, 64'd1, 64'd1, 1'b0, 1'b0, 1'b1);

        // Fill the queue; exactly four entries fit despite the rejected instruction.
        for (int i = 4; i < 8; i++)
            issue(mk(3'b000, 5'(i)), 3'(i), 64'(i), 64'd100, 1'b1, 1'b1, 1'b0);
        x_issue_valid_i = 1'b1; x_issue_instr_i = mk(3'b000, 5'd9);
        #1;
        chk("full_ready_low", {63'd0, x_issue_ready_o}, 64'd0);
        x_issue_valid_i = 1'b0;
        step();
        push_exp(3'd4, 64'd104, 5'd4, 1'b1, 1'b0, 6'd0);
        commit(3'd4, 1'b0);
        got_hs = 1'b0;
        for (int k = 0; k < 12 && !got_hs; k++) begin
            if (x_result_valid_o && x_result_ready_i) begin
                step();
                chk("ready_after_pop", {63'd0, x_issue_ready_o}, 64'd1);
                got_hs = 1'b1;
            end else begin
                chk("ready_while_full", {63'd0, x_issue_ready_o}, 64'd0);
                step();
            end
        end
        chk("full_pop_handshake_seen", {63'd0, got_hs}, 64'd1);
        push_exp(3'd6, 64'd106, 5'd6, 1'b1, 1'b0, 6'd0);
        commit(3'd5, 1'b1);
        commit(3'd6, 1'b0);
        commit(3'd7, 1'b1);
        drain();

        // EXC op raises exception code 2 without writeback.
        push_exp(3'd3, 64'd0, 5'd9, 1'b0, 1'b1, 6'd2);
        issue(mk(3'b011, 5'd9), 3'd3, 64'd5, 64'd6, 1'b1, 1'b0, 1'b1);
        drain();

        // Missing rs2 operand stalls the issue handshake until both operands are valid.
        push_exp(3'd2, 64'd0, 5'd12, 1'b0, 1'b0, 6'd0);
        x_issue_valid_i = 1'b1; x_issue_instr_i = mk(3'b010, 5'd12); x_issue_id_i = 3'd2;
        x_issue_rs_valid_i = 2'b01;
        #1;
        chk("rs_valid_ready_low", {63'd0, x_issue_ready_o}, 64'd0);
        step();
        chk("rs_valid_ready_low2", {63'd0, x_issue_ready_o}, 64'd0);
        x_issue_rs_valid_i = 2'b11; x_commit_valid_i = 1'b1; x_commit_id_i = 3'd2;
        #1;
        chk("rs_valid_ready_high", {63'd0, x_issue_ready_o}, 64'd1);
        chk("nop_writeback", {63'd0, x_issue_writeback_o}, 64'd0);
        step();
        x_issue_valid_i = 1'b0; x_commit_valid_i = 1'b0;
        drain();

        repeat (5) step();
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/cvxif_copro_responder.md
# cvxif_copro_responder

Coprocessor-side responder for the CORE-V-X-Interface (issue, commit, result channels), answering the offload requests the execute stage's CV-X-IF functional unit drives. Decodes a small custom-3 instruction set, queues accepted instructions in order, and waits for commit or kill from the core. It then executes each committed instruction with a fixed per-op latency and returns one result per committed instruction under result-channel backpressure. Used as the reference coprocessor for CvxifEn configurations and for interface verification.

## Interface
- XLEN, 64: operand/result width
- IdWidth, 3: instruction id width (matches TRANS_ID_BITS)
- Depth, 4: pending-instruction queue entries, power of two, >=2
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- x_issue_valid_i  in  1  issue request valid
- x_issue_ready_o  out  1  issue handshake completes when valid&ready
- x_issue_instr_i  in  32  offloaded instruction
- x_issue_id_i  in  IdWidth  instruction id
- x_issue_rs1_i, x_issue_rs2_i  in  XLEN  source operands
- x_issue_rs_valid_i  in  2  operand valid bits {rs2,rs1}
- x_issue_accept_o  out  1  instruction accepted (combinational, valid with handshake)
- x_issue_writeback_o  out  1  accepted instruction will write rd
- x_commit_valid_i  in  1  commit message valid (no ready; always consumed)
- x_commit_id_i  in  IdWidth  id being committed/killed
- x_commit_kill_i  in  1  1 = kill, 0 = commit
- x_result_valid_o  out  1  result valid
- x_result_ready_i  in  1  core accepts result
- x_result_id_o  out  IdWidth  result id
- x_result_data_o  out  XLEN  result data
- x_result_rd_o  out  5  destination register
- x_result_we_o  out  1  register write enable
- x_result_exc_o  out  1  exception flag
- x_result_exccode_o  out  6  exception code

## Operation
- Decode: accept iff instr[6:0]==7'b1111011 and funct3 (instr[14:12]) in {000,001,010,011}; otherwise accept=0, writeback=0, nothing enqueued.
- Ops: 000 ADD rd=rs1+rs2 (mod 2^XLEN), latency 1, we=1; 001 SHL rd=rs1<<rs2[5:0] (rs2[4:0] when XLEN=32), latency 4, we=1; 010 NOP, latency 1, we=0, data=0; 011 EXC, latency 1, we=0, exc=1, exccode=6'd2.
- x_issue_writeback_o = accept & (funct3 is 000 or 001).
- x_issue_ready_o = !full & (rs_valid==2'b11). Non-accepted instructions also complete the handshake under the same condition.
- Enqueue on valid&ready&accept: store {id, rd=instr[11:7], funct3, rs1, rs2, committed=0, killed=0}.
- Commit: on x_commit_valid_i, each pending entry with matching id sets committed=1, and killed=x_commit_kill_i. A commit to an id issued in the same cycle applies to the new entry. Unknown ids are ignored. A second commit to an already-committed entry is ignored.
- In-order execution from head only; FSM states:
  - IDLE: head committed & !killed -> EXEC (counter=latency-1); head killed -> pop, stay IDLE; else stay.
  - EXEC: counter==0 -> RESP with result registered; else decrement.
  - RESP: x_result_valid_o=1; on x_result_ready_i pop head -> IDLE.
- Result fields are held stable while valid && !ready.
- Queue full: issue_ready=0. Simultaneous pop and enqueue when full: not allowed; ready depends only on the registered full flag.
- Reset mid-operation clears queue, FSM to IDLE; in-flight ids are lost (core resets together).

## Timing
- Reset values: x_issue_ready_o=0 while in reset (rs_valid still gates it afterwards), x_result_valid_o=0, all result fields 0, accept/writeback combinational from inputs.
- Issue at cycle t, commit at t or later: head eligible at the later of t+1 and commit cycle+1 (entry visible in IDLE).
- IDLE sees eligible head at cycle c: ADD/NOP/EXC result_valid at c+2 (1 EXEC cycle); SHL at c+5 (4 EXEC cycles).
- Killed head is dropped in 1 cycle; the next entry is evaluated the following cycle.
- Back-to-back committed ADDs with ready=1: one result every 3 cycles.

## Test plan
- Issue ADD id=1 rd=5 rs1=3 rs2=4, commit id=1 same cycle -> accept=1, writeback=1; result id=1 data=7 rd=5 we=1 exc=0 three cycles after issue.
- Issue SHL rs1=1 rs2=8, commit, hold result_ready=0 for 3 cycles -> result data=256 appears 6 cycles after issue and stays stable until ready.
- Issue opcode 0x33 -> accept=0, no result; issue ready=1; queue count unchanged.
- Issue ids 0,1,2 (ADD); kill id 1, commit 0 and 2 -> results for ids 0 and 2 only, in order.
- Fill 4 entries without commit -> issue_ready=0 on the 5th; commit id of head -> ready returns 1 the cycle after its result handshake.
- Issue EXC id=3, commit -> result exc=1 exccode=2 we=0; rs_valid=2'b01 on issue -> ready=0 until both valid.
